// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and digit limits for the stopwatch counting core.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_ONES_MAX = 4'd9;
    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t MIN_ONES_MAX = 4'd9;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Multi-flop synchronizer followed by a registered rising-edge
//               detector. A rising edge on d_in yields a one-cycle pulse
//               SYNC_STAGES+1 cycles later; a held level yields one pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk100MHz,
    input  logic rst,
    input  logic d_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    // Shift the asynchronous level through the synchronizer chain
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
        end
    end

    // Register the rising edge of the synchronized level as a single pulse
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign pulse_out = r_pulse;

endmodule : edge_sync
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_core
// Description : MM:SS BCD stopwatch counter with start/stop/clear control.
//               The 1 Hz tick is sampled as data on the 100 MHz clock.
//               Optional lap-hold display freeze when STOPWATCH_LAP_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int MAX_MIN_TENS = 5
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        overflow,
    output logic        lap_active
);

    localparam bcd_digit_t C_MIN_TENS_MAX = bcd_digit_t'(MAX_MIN_TENS);

    logic       w_tick;
    logic       w_start;
    logic       w_stop;
    logic       w_clear;
    logic       w_lap;

    sw_state_t  r_state;
    sw_state_t  w_next;
    logic       r_running;
    logic       r_overflow;

    bcd_digit_t r_sec_ones;
    bcd_digit_t r_sec_tens;
    bcd_digit_t r_min_ones;
    bcd_digit_t r_min_tens;

    logic       w_count_en;
    logic       w_clear_cnt;
    logic       w_c0;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic [15:0] w_live;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick  (.clk100MHz(clk100MHz), .rst(rst), .d_in(tick_in),   .pulse_out(w_tick));
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (.clk100MHz(clk100MHz), .rst(rst), .d_in(btn_start), .pulse_out(w_start));
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop  (.clk100MHz(clk100MHz), .rst(rst), .d_in(btn_stop),  .pulse_out(w_stop));
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (.clk100MHz(clk100MHz), .rst(rst), .d_in(btn_clear), .pulse_out(w_clear));
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap   (.clk100MHz(clk100MHz), .rst(rst), .d_in(btn_lap),   .pulse_out(w_lap));

    // Next-state decode; clear beats stop beats start, illegal pulses dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = RUN;
            RUN:     if (w_stop)  w_next = PAUSE;
            PAUSE: begin
                if (w_clear)      w_next = IDLE;
                else if (w_start) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
    end

    // Ticks count only in RUN (including the cycle a stop takes effect)
    assign w_count_en  = (r_state == RUN) && w_tick;
    assign w_clear_cnt = (r_state == PAUSE) && w_clear;

    // Ripple-carry terms, all resolved within the tick cycle
    assign w_c0 = (r_sec_ones == SEC_ONES_MAX);
    assign w_c1 = w_c0 && (r_sec_tens == SEC_TENS_MAX);
    assign w_c2 = w_c1 && (r_min_ones == MIN_ONES_MAX);
    assign w_c3 = w_c2 && (r_min_tens == C_MIN_TENS_MAX);

    // State register and registered running flag
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == RUN);
        end
    end

    // BCD digit counters with sticky overflow on full wrap
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_sec_ones <= '0;
            r_sec_tens <= '0;
            r_min_ones <= '0;
            r_min_tens <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear_cnt) begin
            r_sec_ones <= '0;
            r_sec_tens <= '0;
            r_min_ones <= '0;
            r_min_tens <= '0;
            r_overflow <= 1'b0;
        end else if (w_count_en) begin
            r_sec_ones <= w_c0 ? '0 : r_sec_ones + 4'd1;
            if (w_c0) r_sec_tens <= w_c1 ? '0 : r_sec_tens + 4'd1;
            if (w_c1) r_min_ones <= w_c2 ? '0 : r_min_ones + 4'd1;
            if (w_c2) r_min_tens <= w_c3 ? '0 : r_min_tens + 4'd1;
            if (w_c3) r_overflow <= 1'b1;
        end
    end

    assign w_live   = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
    assign running  = r_running;
    assign overflow = r_overflow;

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_hold;
    logic [15:0] r_lap_reg;

    // Lap hold toggles on lap pulses in RUN; clear in PAUSE releases it
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_lap_hold <= 1'b0;
            r_lap_reg  <= '0;
        end else if (w_clear_cnt) begin
            r_lap_hold <= 1'b0;
        end else if ((r_state == RUN) && w_lap) begin
            r_lap_hold <= ~r_lap_hold;
            if (!r_lap_hold) r_lap_reg <= w_live;
        end
    end

    assign bcd_out    = r_lap_hold ? r_lap_reg : w_live;
    assign lap_active = r_lap_hold;
`else
    logic w_unused_lap;
    assign w_unused_lap = w_lap;
    assign bcd_out      = w_live;
    assign lap_active   = 1'b0;
`endif

endmodule : stopwatch_core
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Directed self-checking bench for stopwatch_core. Lap checks
//               follow STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    localparam int SYNC_STAGES = 2;

    logic        clk100MHz = 1'b0;
    logic        rst       = 1'b1;
    logic        tick_in   = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_stop  = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap   = 1'b0;
    logic [15:0] bcd_out;
    logic        running;
    logic        overflow;
    logic        lap_active;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_core #(.SYNC_STAGES(SYNC_STAGES), .MAX_MIN_TENS(5)) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .tick_in   (tick_in),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .bcd_out   (bcd_out),
        .running   (running),
        .overflow  (overflow),
        .lap_active(lap_active)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk100MHz) tick_in = 1'b1;
            repeat (3) @(negedge clk100MHz);
            tick_in = 1'b0;
            repeat (3) @(negedge clk100MHz);
        end
    endtask

    // sel: 0 start, 1 stop, 2 clear, 3 lap, 4 stop+start together
    task automatic press(input int sel);
        @(negedge clk100MHz);
        case (sel)
            0: btn_start = 1'b1;
            1: btn_stop  = 1'b1;
            2: btn_clear = 1'b1;
            3: btn_lap   = 1'b1;
            default: begin btn_stop = 1'b1; btn_start = 1'b1; end
        endcase
        repeat (3) @(negedge clk100MHz);
        btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        repeat (4) @(negedge clk100MHz);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk100MHz);
        chk("rst_bcd", bcd_out, 16'h0000);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);
        chk("rst_lap", {15'd0, lap_active}, 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk100MHz);

        // Start and count three seconds
        press(0);
        chk("start_running", {15'd0, running}, 16'd1);
        ticks(3);
        chk("three_ticks", bcd_out, 16'h0003);
        chk("three_ticks_ovf", {15'd0, overflow}, 16'd0);

        // Simultaneous stop+start in RUN: stop wins
        press(4);
        chk("stop_start_pause", {15'd0, running}, 16'd0);
        ticks(2);
        chk("pause_ticks_dropped", bcd_out, 16'h0003);

        // Resume; clear in RUN ignored
        press(0);
        chk("resume_running", {15'd0, running}, 16'd1);
        press(2);
        chk("clear_in_run_running", {15'd0, running}, 16'd1);
        chk("clear_in_run_count", bcd_out, 16'h0003);

        // Tick edge to display change latency
        @(negedge clk100MHz) tick_in = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk100MHz);
        chk("latency_early", bcd_out, 16'h0003);
        @(negedge clk100MHz);
        chk("latency_exact", bcd_out, 16'h0004);
        tick_in = 1'b0;
        repeat (4) @(negedge clk100MHz);

        // Held start gives a single pulse
        press(1);
        chk("stop_to_pause", {15'd0, running}, 16'd0);
        @(negedge clk100MHz) btn_start = 1'b1;
        repeat (10) @(negedge clk100MHz);
        chk("held_start_run", {15'd0, running}, 16'd1);
        btn_stop = 1'b1;
        repeat (3) @(negedge clk100MHz);
        btn_stop = 1'b0;
        repeat (980) @(negedge clk100MHz);
        chk("held_start_single_pulse", {15'd0, running}, 16'd0);
        btn_start = 1'b0;
        repeat (4) @(negedge clk100MHz);
        chk("held_start_count", bcd_out, 16'h0004);

        // Clear from PAUSE, stop in IDLE ignored, start again
        press(2);
        chk("clear_count", bcd_out, 16'h0000);
        press(1);
        chk("stop_in_idle", {15'd0, running}, 16'd0);
        press(0);
        chk("idle_start", {15'd0, running}, 16'd1);

        // Digit carries and full wrap
        ticks(59);
        chk("sec_59", bcd_out, 16'h0059);
        ticks(1);
        chk("min_carry", bcd_out, 16'h0100);
        ticks(3539);
        chk("max_5959", bcd_out, 16'h5959);
        chk("max_no_ovf", {15'd0, overflow}, 16'd0);
        ticks(1);
        chk("wrap_0000", bcd_out, 16'h0000);
        chk("wrap_ovf", {15'd0, overflow}, 16'd1);
        ticks(2);
        chk("post_wrap_count", bcd_out, 16'h0002);
        chk("ovf_sticky", {15'd0, overflow}, 16'd1);
        press(1);
        chk("ovf_after_stop", {15'd0, overflow}, 16'd1);
        press(2);
        chk("ovf_cleared", {15'd0, overflow}, 16'd0);
        chk("clear_after_wrap", bcd_out, 16'h0000);
        chk("clear_idle", {15'd0, running}, 16'd0);

        // Lap hold
        press(0);
        ticks(5);
        chk("lap_pre", bcd_out, 16'h0005);
        press(3);
`ifdef STOPWATCH_LAP_EN
        chk("lap_on_active", {15'd0, lap_active}, 16'd1);
        ticks(4);
        chk("lap_frozen", bcd_out, 16'h0005);
        chk("lap_frozen_active", {15'd0, lap_active}, 16'd1);
`else
        chk("lap_off_active", {15'd0, lap_active}, 16'd0);
        ticks(4);
        chk("lap_off_live", bcd_out, 16'h0009);
`endif
        press(3);
        chk("lap_release", bcd_out, 16'h0009);
        chk("lap_release_active", {15'd0, lap_active}, 16'd0);

        // Asynchronous reset mid-count
        ticks(258);
        chk("pre_reset_0427", bcd_out, 16'h0427);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bcd", bcd_out, 16'h0000);
        @(negedge clk100MHz);
        chk("rst_mid_bcd", bcd_out, 16'h0000);
        chk("rst_mid_running", {15'd0, running}, 16'd0);
        chk("rst_mid_ovf", {15'd0, overflow}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_core
`default_nettype wire
